// File: rtl/cpu_control_fsm_if.sv
// Control bundle between the multicycle controller (master) and the CPU datapath (slave).
// The controller consumes the instruction word and ALU flags and drives every datapath enable/select.
interface cpu_control_fsm_if #(
    parameter int REG_WIDTH = 16
);
    logic [REG_WIDTH-1:0] instr;
    logic [4:0]           alu_flags;
    logic                 ir_en;
    logic                 pc_en;
    logic [1:0]           pc_sel;
    logic                 mem_addr_sel;
    logic                 mem_we;
    logic                 rf_we;
    logic [1:0]           muxrf_select;
    logic                 alu_a_sel;
    logic                 alu_b_sel;
    logic [3:0]           alu_op;
    logic [4:0]           psr;

    modport master (
        input  instr, alu_flags,
        output ir_en, pc_en, pc_sel, mem_addr_sel, mem_we, rf_we,
               muxrf_select, alu_a_sel, alu_b_sel, alu_op, psr
    );

    modport slave (
        output instr, alu_flags,
        input  ir_en, pc_en, pc_sel, mem_addr_sel, mem_we, rf_we,
               muxrf_select, alu_a_sel, alu_b_sel, alu_op, psr
    );
endinterface

// File: rtl/cpu_control_fsm.sv
// Multicycle fetch/decode/execute sequencer for the 16-bit CPU.
// Also owns the processor status register that conditional branches and jumps test.
module cpu_control_fsm #(
    parameter int REG_WIDTH     = 16,
    parameter int REG_ADDR_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_control_fsm_if.master     bus
);
    localparam logic [3:0] S_FETCH      = 4'd0;
    localparam logic [3:0] S_FETCH_WAIT = 4'd1;
    localparam logic [3:0] S_DECODE     = 4'd2;
    localparam logic [3:0] S_EXEC_R     = 4'd3;
    localparam logic [3:0] S_EXEC_I     = 4'd4;
    localparam logic [3:0] S_LOAD_ADDR  = 4'd5;
    localparam logic [3:0] S_LOAD_WB    = 4'd6;
    localparam logic [3:0] S_STORE      = 4'd7;
    localparam logic [3:0] S_BCOND      = 4'd8;
    localparam logic [3:0] S_JCOND      = 4'd9;
    localparam logic [3:0] S_PC_INC     = 4'd10;

    localparam logic [REG_ADDR_BITS-1:0] OP_RTYPE  = 'd0;
    localparam logic [REG_ADDR_BITS-1:0] OP_AND    = 'd1;
    localparam logic [REG_ADDR_BITS-1:0] OP_OR     = 'd2;
    localparam logic [REG_ADDR_BITS-1:0] OP_XOR    = 'd3;
    localparam logic [REG_ADDR_BITS-1:0] OP_MEM    = 'd4;
    localparam logic [REG_ADDR_BITS-1:0] OP_ADD    = 'd5;
    localparam logic [REG_ADDR_BITS-1:0] OP_SUB    = 'd9;
    localparam logic [REG_ADDR_BITS-1:0] OP_CMP    = 'd11;
    localparam logic [REG_ADDR_BITS-1:0] OP_BCOND  = 'd12;
    localparam logic [REG_ADDR_BITS-1:0] OP_MOV    = 'd13;
    localparam logic [REG_ADDR_BITS-1:0] OP_LUI    = 'd15;
    localparam logic [REG_ADDR_BITS-1:0] EXT_LOAD  = 'd0;
    localparam logic [REG_ADDR_BITS-1:0] EXT_STOR  = 'd4;
    localparam logic [REG_ADDR_BITS-1:0] EXT_JCOND = 'd12;

    localparam int F_C = 4;
    localparam int F_L = 3;
    localparam int F_F = 2;
    localparam int F_Z = 1;
    localparam int F_N = 0;

    logic [3:0]               state;
    logic [3:0]               state_next;
    logic [4:0]               psr_q;
    logic                     psr_load;
    logic [REG_ADDR_BITS-1:0] op;
    logic [REG_ADDR_BITS-1:0] cond;
    logic [REG_ADDR_BITS-1:0] ext;
    logic                     unused_rsrc;

    logic       ir_en_raw, pc_en_raw, mem_we_raw, rf_we_raw;
    logic [1:0] pc_sel_c, muxrf_c;
    logic       mem_addr_sel_c, alu_a_sel_c, alu_b_sel_c;
    logic [3:0] alu_op_c;

    assign op          = bus.instr[REG_WIDTH-1 -: REG_ADDR_BITS];
    assign cond        = bus.instr[REG_WIDTH-REG_ADDR_BITS-1 -: REG_ADDR_BITS];
    assign ext         = bus.instr[2*REG_ADDR_BITS-1 -: REG_ADDR_BITS];
    // Rsrc only steers the datapath's register read port, never the sequencing.
    assign unused_rsrc = ^bus.instr[REG_ADDR_BITS-1:0];

    function automatic logic is_alu_code(input logic [REG_ADDR_BITS-1:0] c);
        return c inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_CMP, OP_MOV};
    endfunction

    function automatic logic cond_taken(input logic [REG_ADDR_BITS-1:0] cc, input logic [4:0] f);
        case (cc)
            'd0:     return  f[F_Z];
            'd1:     return !f[F_Z];
            'd2:     return  f[F_C];
            'd3:     return !f[F_C];
            'd6:     return  f[F_N];
            'd7:     return !f[F_N];
            'd8:     return  f[F_F];
            'd9:     return !f[F_F];
            'd10:    return  f[F_L];
            'd11:    return !f[F_L];
            'd14:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:      state_next = S_FETCH_WAIT;
            S_FETCH_WAIT: state_next = S_DECODE;
            S_DECODE: begin
                if (op == OP_RTYPE && is_alu_code(ext))       state_next = S_EXEC_R;
                else if (is_alu_code(op) || op == OP_LUI)     state_next = S_EXEC_I;
                else if (op == OP_MEM && ext == EXT_LOAD)     state_next = S_LOAD_ADDR;
                else if (op == OP_MEM && ext == EXT_STOR)     state_next = S_STORE;
                else if (op == OP_MEM && ext == EXT_JCOND)    state_next = S_JCOND;
                else if (op == OP_BCOND)                      state_next = S_BCOND;
                else                                          state_next = S_PC_INC;
            end
            S_LOAD_ADDR:  state_next = S_LOAD_WB;
            default:      state_next = S_FETCH;
        endcase
    end

    always_comb begin
        ir_en_raw      = 1'b0;
        pc_en_raw      = 1'b0;
        mem_we_raw     = 1'b0;
        rf_we_raw      = 1'b0;
        pc_sel_c       = 2'b00;
        muxrf_c        = 2'b00;
        mem_addr_sel_c = 1'b0;
        alu_a_sel_c    = 1'b0;
        alu_b_sel_c    = 1'b0;
        alu_op_c       = 4'd0;
        case (state)
            S_FETCH_WAIT: ir_en_raw = 1'b1;
            S_EXEC_R: begin
                alu_op_c  = ext;
                pc_en_raw = 1'b1;
                if (ext == OP_MOV) begin
                    rf_we_raw = 1'b1;
                    muxrf_c   = 2'b10;
                end else if (ext != OP_CMP) begin
                    rf_we_raw = 1'b1;
                end
            end
            S_EXEC_I: begin
                alu_op_c    = op;
                alu_b_sel_c = 1'b1;
                pc_en_raw   = 1'b1;
                if (op == OP_MOV || op == OP_LUI) begin
                    rf_we_raw = 1'b1;
                    muxrf_c   = 2'b11;
                end else if (op != OP_CMP) begin
                    rf_we_raw = 1'b1;
                end
            end
            S_LOAD_ADDR: mem_addr_sel_c = 1'b1;
            S_LOAD_WB: begin
                mem_addr_sel_c = 1'b1;
                rf_we_raw      = 1'b1;
                muxrf_c        = 2'b01;
                pc_en_raw      = 1'b1;
            end
            S_STORE: begin
                mem_addr_sel_c = 1'b1;
                mem_we_raw     = 1'b1;
                pc_en_raw      = 1'b1;
            end
            // Branch target is PC + sign-extended displacement computed by the ALU.
            S_BCOND: begin
                alu_a_sel_c = 1'b1;
                alu_b_sel_c = 1'b1;
                alu_op_c    = OP_ADD;
                pc_en_raw   = 1'b1;
                pc_sel_c    = cond_taken(cond, psr_q) ? 2'b01 : 2'b00;
            end
            S_JCOND: begin
                pc_en_raw = 1'b1;
                pc_sel_c  = cond_taken(cond, psr_q) ? 2'b10 : 2'b00;
            end
            S_PC_INC: pc_en_raw = 1'b1;
            default: ;
        endcase
    end

    // Moves never touch the flags, so a compare result survives an intervening MOV/MOVI/LUI.
    assign psr_load = (state == S_EXEC_R && ext != OP_MOV) ||
                      (state == S_EXEC_I && op != OP_MOV && op != OP_LUI);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_FETCH;
            psr_q <= 5'd0;
        end else begin
            state <= state_next;
            if (psr_load) psr_q <= bus.alu_flags;
        end
    end

    // Write/load strobes are suppressed the moment reset drops, even mid-instruction.
    assign bus.ir_en        = ir_en_raw  & reset;
    assign bus.pc_en        = pc_en_raw  & reset;
    assign bus.mem_we       = mem_we_raw & reset;
    assign bus.rf_we        = rf_we_raw  & reset;
    assign bus.pc_sel       = pc_sel_c;
    assign bus.muxrf_select = muxrf_c;
    assign bus.mem_addr_sel = mem_addr_sel_c;
    assign bus.alu_a_sel    = alu_a_sel_c;
    assign bus.alu_b_sel    = alu_b_sel_c;
    assign bus.alu_op       = alu_op_c;
    assign bus.psr          = psr_q;
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Self-checking bench for cpu_control_fsm: directed table, reset corner sequence, random instructions vs model.
module tb_cpu_control_fsm;
    typedef struct packed {
        logic       ir_en;
        logic       pc_en;
        logic [1:0] pc_sel;
        logic       mem_addr_sel;
        logic       mem_we;
        logic       rf_we;
        logic [1:0] muxrf;
        logic       a_sel;
        logic       b_sel;
        logic [3:0] alu_op;
        logic [4:0] psr;
    } out_t;

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  flags;
        int          ncyc;
        out_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    out_t exp_q[$];
    logic [4:0] m_psr;

    cpu_control_fsm_if #(.REG_WIDTH(16)) bus ();

    cpu_control_fsm #(.REG_WIDTH(16), .REG_ADDR_BITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic ir, input logic pce, input logic [1:0] pcs,
                                input logic mas, input logic mwe, input logic rwe,
                                input logic [1:0] mux, input logic as, input logic bs,
                                input logic [3:0] aop, input logic [4:0] ps);
        out_t o;
        o.ir_en = ir; o.pc_en = pce; o.pc_sel = pcs; o.mem_addr_sel = mas;
        o.mem_we = mwe; o.rf_we = rwe; o.muxrf = mux; o.a_sel = as;
        o.b_sel = bs; o.alu_op = aop; o.psr = ps;
        return o;
    endfunction

    function automatic out_t get_out();
        out_t o;
        o.ir_en = bus.ir_en; o.pc_en = bus.pc_en; o.pc_sel = bus.pc_sel;
        o.mem_addr_sel = bus.mem_addr_sel; o.mem_we = bus.mem_we; o.rf_we = bus.rf_we;
        o.muxrf = bus.muxrf_select; o.a_sel = bus.alu_a_sel; o.b_sel = bus.alu_b_sel;
        o.alu_op = bus.alu_op; o.psr = bus.psr;
        return o;
    endfunction

    task automatic chk(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %05h expected %05h", name, act, exp);
    endtask

    task automatic chk_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Condition code -> flag position by pair (EQ/NE, CS/CC, -, GT/LE, FS/FC, LO/HS); odd code = negated.
    function automatic logic taken(input logic [3:0] cd, input logic [4:0] ps);
        int bit_of_pair[6] = '{1, 4, -1, 0, 2, 3};
        int pair;
        if (cd == 4'd14) return 1'b1;
        if (cd > 4'd11) return 1'b0;
        pair = int'(cd) / 2;
        if (bit_of_pair[pair] < 0) return 1'b0;
        return ps[bit_of_pair[pair]] ^ cd[0];
    endfunction

    // Instruction-level model: expected per-cycle outputs for one instruction, updates m_psr.
    task automatic model(input logic [15:0] ins, input logic [4:0] fl);
        logic [3:0] op, cd, ext;
        out_t base, e;
        op = ins[15:12]; cd = ins[11:8]; ext = ins[7:4];
        exp_q.delete();
        base = '0;
        base.psr = m_psr;
        exp_q.push_back(base);
        e = base; e.ir_en = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(base);
        e = base; e.pc_en = 1'b1;
        if (op == 4'd0 && (ext inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13})) begin
            e.alu_op = ext;
            if (ext == 4'd13) begin e.rf_we = 1'b1; e.muxrf = 2'd2; end
            else if (ext != 4'd11) e.rf_we = 1'b1;
            exp_q.push_back(e);
            if (ext != 4'd13) m_psr = fl;
        end else if (op inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd9, 4'd11, 4'd13, 4'd15}) begin
            e.alu_op = op; e.b_sel = 1'b1;
            if (op == 4'd13 || op == 4'd15) begin e.rf_we = 1'b1; e.muxrf = 2'd3; end
            else if (op != 4'd11) e.rf_we = 1'b1;
            exp_q.push_back(e);
            if (op != 4'd13 && op != 4'd15) m_psr = fl;
        end else if (op == 4'd4 && ext == 4'd0) begin
            out_t a = base;
            a.mem_addr_sel = 1'b1;
            exp_q.push_back(a);
            e.mem_addr_sel = 1'b1; e.rf_we = 1'b1; e.muxrf = 2'd1;
            exp_q.push_back(e);
        end else if (op == 4'd4 && ext == 4'd4) begin
            e.mem_addr_sel = 1'b1; e.mem_we = 1'b1;
            exp_q.push_back(e);
        end else if (op == 4'd4 && ext == 4'd12) begin
            e.pc_sel = taken(cd, m_psr) ? 2'd2 : 2'd0;
            exp_q.push_back(e);
        end else if (op == 4'd12) begin
            e.a_sel = 1'b1; e.b_sel = 1'b1; e.alu_op = 4'd5;
            e.pc_sel = taken(cd, m_psr) ? 2'd1 : 2'd0;
            exp_q.push_back(e);
        end else begin
            exp_q.push_back(e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[14];
        int op_pick[11] = '{0, 1, 2, 3, 5, 9, 11, 13, 15, 4, 12};
        int alu_pick[7] = '{1, 2, 3, 5, 9, 11, 13};
        int mem_pick[3] = '{0, 4, 12};
        logic [15:0] ins;
        logic [4:0] fl;

        tbl[0]  = '{16'h0152, 5'b00010, 4, mk(0,1,2'd0,0,0,1,2'd0,0,0,4'd5,5'b00000)};
        tbl[1]  = '{16'hB305, 5'b00010, 4, mk(0,1,2'd0,0,0,0,2'd0,0,1,4'd11,5'b00010)};
        tbl[2]  = '{16'hC0FC, 5'b00000, 4, mk(0,1,2'd1,0,0,0,2'd0,1,1,4'd5,5'b00010)};
        tbl[3]  = '{16'hB305, 5'b00000, 4, mk(0,1,2'd0,0,0,0,2'd0,0,1,4'd11,5'b00010)};
        tbl[4]  = '{16'hC0FC, 5'b00010, 4, mk(0,1,2'd0,0,0,0,2'd0,1,1,4'd5,5'b00000)};
        tbl[5]  = '{16'h4402, 5'b11111, 5, mk(0,1,2'd0,1,0,1,2'd1,0,0,4'd0,5'b00000)};
        tbl[6]  = '{16'h4543, 5'b00000, 4, mk(0,1,2'd0,1,1,0,2'd0,0,0,4'd0,5'b00000)};
        tbl[7]  = '{16'h4EC7, 5'b00000, 4, mk(0,1,2'd2,0,0,0,2'd0,0,0,4'd0,5'b00000)};
        tbl[8]  = '{16'h44C7, 5'b00000, 4, mk(0,1,2'd0,0,0,0,2'd0,0,0,4'd0,5'b00000)};
        tbl[9]  = '{16'hB305, 5'b10000, 4, mk(0,1,2'd0,0,0,0,2'd0,0,1,4'd11,5'b00000)};
        tbl[10] = '{16'hD1FF, 5'b01111, 4, mk(0,1,2'd0,0,0,1,2'd3,0,1,4'd13,5'b10000)};
        tbl[11] = '{16'h7000, 5'b11111, 4, mk(0,1,2'd0,0,0,0,2'd0,0,0,4'd0,5'b10000)};
        tbl[12] = '{16'h01D2, 5'b01111, 4, mk(0,1,2'd0,0,0,1,2'd2,0,0,4'd13,5'b10000)};
        tbl[13] = '{16'h7000, 5'b00000, 4, mk(0,1,2'd0,0,0,0,2'd0,0,0,4'd0,5'b10000)};

        bus.instr = 16'h0000;
        bus.alu_flags = 5'b00000;
        reset = 1'b0;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("reset_state", get_out(), '0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        // Directed table, run back to back so psr carries between entries.
        for (int i = 0; i < 14; i++) begin
            bus.instr = tbl[i].instr;
            bus.alu_flags = tbl[i].flags;
            for (int c = 1; c <= tbl[i].ncyc; c++) begin
                @(negedge clk);
                if (c == 2) chk_bit($sformatf("tbl%0d_ir_en", i), bus.ir_en, 1'b1);
                if (c == tbl[i].ncyc) chk($sformatf("tbl%0d_exec", i), get_out(), tbl[i].exp);
                @(posedge clk); #1;
            end
        end

        // Reset dropped during LOAD_WB for two edges: no write, psr cleared, clean restart.
        bus.instr = 16'h4402;
        bus.alu_flags = 5'b00000;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 4) chk("load_addr", get_out(), mk(0,0,2'd0,1,0,0,2'd0,0,0,4'd0,5'b10000));
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("load_wb", get_out(), mk(0,1,2'd0,1,0,1,2'd1,0,0,4'd0,5'b10000));
        reset = 1'b0;
        #1;
        chk_bit("rst_gate_rf_we", bus.rf_we, 1'b0);
        chk_bit("rst_gate_pc_en", bus.pc_en, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_fetch", get_out(), '0);
        @(posedge clk); #1;
        reset = 1'b1;
        bus.instr = 16'h7000;
        @(negedge clk);
        chk("post_rst_c1", get_out(), '0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_c2", get_out(), mk(1,0,2'd0,0,0,0,2'd0,0,0,4'd0,5'b00000));
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("post_rst_nop", get_out(), mk(0,1,2'd0,0,0,0,2'd0,0,0,4'd0,5'b00000));
        @(posedge clk); #1;

        // Random instructions against the instruction-level model.
        m_psr = 5'b00000;
        for (int n = 0; n < 200; n++) begin
            ins = 16'($urandom);
            fl = 5'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                ins[15:12] = 4'(op_pick[$urandom_range(0, 10)]);
                if (ins[15:12] == 4'd0) ins[7:4] = 4'(alu_pick[$urandom_range(0, 6)]);
                if (ins[15:12] == 4'd4) ins[7:4] = 4'(mem_pick[$urandom_range(0, 2)]);
            end
            bus.instr = ins;
            bus.alu_flags = fl;
            model(ins, fl);
            for (int c = 0; c < exp_q.size(); c++) begin
                @(negedge clk);
                chk($sformatf("rnd%0d_%04h_c%0d", n, ins, c + 1), get_out(), exp_q[c]);
                @(posedge clk); #1;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
- Multicycle control unit for the 16-bit CPU.
- Takes the instruction word from the instruction register and the ALU flags.
- Sequences fetch/decode/execute and drives the register-file write enable, the register-file data-in mux select, memory, PC and ALU-operand controls.
- Holds the processor status register (PSR) that conditional branches and jumps evaluate.

Parameters:
REG_WIDTH, 16, instruction/data word width
REG_ADDR_BITS, 4, width of register-address and opcode fields

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset
instr  input  REG_WIDTH  instruction register contents: [15:12] op, [11:8] Rdest/cond, [7:4] opext/imm-hi, [3:0] Rsrc/imm-lo
alu_flags  input  5  {C,L,F,Z,N} from ALU, valid combinationally in execute states
ir_en  output  1  instruction register load enable
pc_en  output  1  PC load enable
pc_sel  output  2  00 PC+1, 01 ALU result (branch), 10 Rsrc register (jump)
mem_addr_sel  output  1  0 address=PC, 1 address=Rsrc register
mem_we  output  1  memory write enable (data = Rdest register)
rf_we  output  1  register-file write enable
muxrf_select  output  2  00 ALU, 01 memory data, 10 Rsrc register, 11 immediate path
alu_a_sel  output  1  0 Rdest register, 1 PC
alu_b_sel  output  1  0 Rsrc register, 1 sign-extended immediate
alu_op  output  4  ALU operation code
psr  output  5  registered flags {C,L,F,Z,N}

Behaviour:
- Reset: when reset==0 at a rising edge, state<=FETCH and psr<=0. All outputs are 0 in FETCH. While reset==0, rf_we, mem_we, pc_en, ir_en are forced 0 combinationally in any state. Reset mid-instruction abandons it with no write.
- Memory is synchronous read, 1-cycle latency. Register-file reads are combinational.
- States and outputs (unlisted outputs are 0):
  - FETCH: mem_addr_sel=0. Next FETCH_WAIT.
  - FETCH_WAIT: ir_en=1. Next DECODE.
  - DECODE: no enables. Next state by instr:
    - op=0000 with opext in {ADD 0101, SUB 1001, CMP 1011, AND 0001, OR 0010, XOR 0011, MOV 1101} -> EXEC_R.
    - op in {0101, 1001, 1011, 0001, 0010, 0011, 1101, LUI 1111} -> EXEC_I.
    - op=0100, opext=0000 -> LOAD_ADDR. op=0100, opext=0100 -> STORE. op=0100, opext=1100 -> JCOND.
    - op=1100 -> BCOND.
    - Anything else is a NOP -> PC_INC.
  - EXEC_R: alu_op=opext, alu_b_sel=0. MOV: rf_we=1, muxrf_select=10. CMP: rf_we=0. Others: rf_we=1, muxrf_select=00. pc_en=1, pc_sel=00. Next FETCH.
  - EXEC_I: alu_op=op, alu_b_sel=1. MOVI and LUI: rf_we=1, muxrf_select=11. CMPI: rf_we=0. Others: rf_we=1, muxrf_select=00. pc_en=1, pc_sel=00. Next FETCH.
  - PSR update: at the end of EXEC_R/EXEC_I, psr<=alu_flags, except for MOV, MOVI and LUI, where psr holds.
  - LOAD_ADDR: mem_addr_sel=1. Next LOAD_WB.
  - LOAD_WB: mem_addr_sel=1, rf_we=1, muxrf_select=01, pc_en=1, pc_sel=00. Next FETCH.
  - STORE: mem_addr_sel=1, mem_we=1, pc_en=1, pc_sel=00. Next FETCH.
  - BCOND: alu_a_sel=1, alu_b_sel=1, alu_op=0101, pc_en=1. pc_sel=01 if taken, else 00. Next FETCH.
  - JCOND: pc_en=1. pc_sel=10 if taken, else 00. Next FETCH.
  - PC_INC: pc_en=1, pc_sel=00. Next FETCH.
- Condition codes (field [11:8], evaluated on psr, never on live alu_flags):
  - EQ 0000: Z=1. NE 0001: Z=0.
  - CS 0010: C=1. CC 0011: C=0.
  - GT 0110: N=1. LE 0111: N=0.
  - FS 1000: F=1. FC 1001: F=0.
  - LO 1010: L=1. HS 1011: L=0.
  - UC 1110: always taken.
  - All other codes: never taken.
- Latency: ALU, store, branch, jump and NOP instructions take 4 cycles. LOAD takes 5 cycles.
- Exactly one pc_en pulse per instruction. At most one of rf_we/mem_we is high in any cycle.

Test Plan:
- Reset low for 2 cycles in LOAD_WB -> rf_we=0 throughout; psr=0; state FETCH; first ir_en exactly 2 cycles after reset rises.
- instr=0x0152 (ADD R1,R2), alu_flags=5'b00010 -> ir_en in cycle 2; rf_we=1, muxrf_select=00, alu_op=0101, pc_en=1 in cycle 4; psr=5'b00010 afterwards.
- CMPI 0xB305 with alu_flags Z=1, then BCOND EQ 0xC0FC -> in the BCOND execute cycle pc_en=1, pc_sel=01, alu_a_sel=1, alu_b_sel=1. Repeat with Z=0 -> pc_sel=00.
- LOAD 0x4402 -> mem_addr_sel=1 in cycles 4-5; rf_we=1 and muxrf_select=01 only in cycle 5; next ir_en in cycle 7.
- STORE 0x4543, then JCOND UC 0x4EC7 -> mem_we=1 for one cycle with rf_we=0; jump gives pc_sel=10. JCOND with code 0100 -> pc_sel=00.
- MOVI 0xD1FF after psr=5'b10000 -> rf_we=1, muxrf_select=11, psr unchanged. Undefined op 0x7000 -> only pc_en with pc_sel=00; no writes.
